// File: rtl/wm_phase_timer.sv
// Washing-machine phase timer: issues per-phase kick codes to the controller,
// waits for the matching acknowledge, times each phase and reports completion
// or acknowledge timeout.
module wm_phase_timer #(
  parameter int unsigned SOAK_T   = 8,
  parameter int unsigned WASH_T   = 10,
  parameter int unsigned HI_EXTRA = 4,
  parameter int unsigned DRAIN_T  = 4,
  parameter int unsigned RINSE_T  = 6,
  parameter int unsigned SPIN_T   = 5,
  parameter int unsigned ACK_T    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic select,
  input  logic stop,
  input  logic idle,
  input  logic soak_low,
  input  logic soak_high,
  input  logic wash_low,
  input  logic wash_high,
  input  logic drain,
  input  logic rinse,
  input  logic spin,
  output logic timer_soak_low,
  output logic timer_soak_high,
  output logic timer_wash_low,
  output logic timer_wash_high,
  output logic timer_drain,
  output logic timer_rinse,
  output logic timer_spin,
  output logic done,
  output logic fault
);

  // Counter load value: duration-1, with a zero duration behaving as one cycle.
  function automatic logic [15:0] dm1(input int unsigned d);
    return (d == 0) ? 16'd0 : 16'(d - 1);
  endfunction

  localparam logic [15:0] SOAK_N = dm1(SOAK_T);
  localparam logic [15:0] SOAK_H = dm1(SOAK_T + HI_EXTRA);
  localparam logic [15:0] WASH_N = dm1(WASH_T);
  localparam logic [15:0] WASH_H = dm1(WASH_T + HI_EXTRA);
  localparam logic [15:0] DRN_L  = dm1(DRAIN_T);
  localparam logic [15:0] RNS_L  = dm1(RINSE_T);
  localparam logic [15:0] SPN_L  = dm1(SPIN_T);
  localparam logic [15:0] ACK_L  = dm1(ACK_T);

  typedef enum logic [3:0] {
    ARM, K_SOAK, R_SOAK, K_WASH, R_WASH, K_DRAIN, R_DRAIN,
    K_RINSE, R_RINSE, K_SPIN, R_SPIN, K_END
  } state_t;

  state_t      state_q, state_d, run_st, nxt_kick;
  logic [15:0] cnt_q, cnt_d, ack_q, ack_d, load;
  logic        sel_q, sel_d, fault_q, fault_d, done_q, done_d;
  logic        kick, ack;
  logic [6:0]  code_d, code_q;

  // Next-state logic: per-state lookup of acknowledge, run target and duration.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    sel_d    = sel_q;
    fault_d  = fault_q;
    done_d   = 1'b0;
    kick     = 1'b0;
    ack      = 1'b0;
    run_st   = ARM;
    nxt_kick = ARM;
    load     = '0;
    case (state_q)
      K_SOAK:  begin kick = 1'b1; ack = sel_q ? soak_high : soak_low;
                     run_st = R_SOAK; load = sel_q ? SOAK_H : SOAK_N; end
      K_WASH:  begin kick = 1'b1; ack = sel_q ? wash_high : wash_low;
                     run_st = R_WASH; load = sel_q ? WASH_H : WASH_N; end
      K_DRAIN: begin kick = 1'b1; ack = drain & ~rinse; run_st = R_DRAIN; load = DRN_L; end
      K_RINSE: begin kick = 1'b1; ack = rinse; run_st = R_RINSE; load = RNS_L; end
      K_SPIN:  begin kick = 1'b1; ack = spin;  run_st = R_SPIN;  load = SPN_L; end
      K_END:   begin kick = 1'b1; ack = ~spin; run_st = ARM; end
      R_SOAK:  nxt_kick = K_WASH;
      R_WASH:  nxt_kick = K_DRAIN;
      R_DRAIN: nxt_kick = K_RINSE;
      R_RINSE: nxt_kick = K_SPIN;
      R_SPIN:  nxt_kick = K_END;
      default: ;
    endcase

    if (state_q == ARM) begin
      if (start && !stop) begin
        sel_d   = select;
        fault_d = 1'b0;
        ack_d   = '0;
        state_d = K_SOAK;
      end
    end else if (stop || idle) begin
      state_d = ARM;
    end else if (kick) begin
      if (ack) begin
        state_d = run_st;
        cnt_d   = load;
        done_d  = (state_q == K_END);
      end else if (ack_q == ACK_L) begin
        fault_d = 1'b1;
        state_d = ARM;
      end else begin
        ack_d = ack_q + 16'd1;
      end
    end else if (cnt_q == '0) begin
      state_d = nxt_kick;
      ack_d   = '0;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  // Timer code for the upcoming state, so the register shows it in that state's first cycle.
  always_comb begin
    code_d = '0;
    case (state_d)
      K_SOAK:  code_d[6 - {2'b0, sel_d}] = 1'b1;
      K_WASH:  code_d[4 - {2'b0, sel_d}] = 1'b1;
      K_DRAIN: code_d[2] = 1'b1;
      K_RINSE: code_d[2:1] = 2'b11;
      K_SPIN:  begin code_d[2] = 1'b1; code_d[0] = 1'b1; end
      R_SPIN:  code_d[0] = 1'b1;
      default: ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARM;
      cnt_q   <= '0;
      ack_q   <= '0;
      sel_q   <= 1'b0;
      fault_q <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      fault_q <= fault_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  assign {timer_soak_low, timer_soak_high, timer_wash_low, timer_wash_high,
          timer_drain, timer_rinse, timer_spin} = code_q;
  assign done  = done_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_wm_phase_timer.sv
// Directed bench for wm_phase_timer: expected output vectors are queued per
// cycle from the documented program timelines and compared at each negedge.
module tb_wm_phase_timer;

  logic clk, rst, start, select, stop, idle, resp;
  logic soak_low, soak_high, wash_low, wash_high, drain, rinse, spin;
  logic timer_soak_low, timer_soak_high, timer_wash_low, timer_wash_high;
  logic timer_drain, timer_rinse, timer_spin, done, fault;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] obs;

  localparam int SL = 8, SH = 7, WL = 6, WH = 5, DR = 4, RI = 3, SP = 2, DN = 1, FT = 0;

  wm_phase_timer dut (
    .clk(clk), .rst(rst), .start(start), .select(select), .stop(stop), .idle(idle),
    .soak_low(soak_low), .soak_high(soak_high), .wash_low(wash_low), .wash_high(wash_high),
    .drain(drain), .rinse(rinse), .spin(spin),
    .timer_soak_low(timer_soak_low), .timer_soak_high(timer_soak_high),
    .timer_wash_low(timer_wash_low), .timer_wash_high(timer_wash_high),
    .timer_drain(timer_drain), .timer_rinse(timer_rinse), .timer_spin(timer_spin),
    .done(done), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: echoes kick codes combinationally when responsive.
  always_comb begin
    soak_low  = resp & timer_soak_low;
    soak_high = resp & timer_soak_high;
    wash_low  = resp & timer_wash_low;
    wash_high = resp & timer_wash_high;
    drain     = resp & timer_drain;
    rinse     = resp & timer_rinse;
    spin      = resp & timer_spin;
  end

  assign obs = {timer_soak_low, timer_soak_high, timer_wash_low, timer_wash_high,
                timer_drain, timer_rinse, timer_spin, done, fault};

  task automatic push(input logic [8:0] v);
    exp_q.push_back(v);
  endtask

  // Queue expected vectors for program cycles first..last (cycle 0 = first soak kick).
  task automatic push_prog(input bit heavy, input int first, input int last);
    int k[6];
    logic [8:0] v;
    if (heavy) begin
      k[0] = 0; k[1] = 13; k[2] = 28; k[3] = 33; k[4] = 40; k[5] = 47;
    end else begin
      k[0] = 0; k[1] = 9;  k[2] = 20; k[3] = 25; k[4] = 32; k[5] = 39;
    end
    for (int c = first; c <= last; c++) begin
      v = '0;
      if (c == k[0]) v[heavy ? SH : SL] = 1'b1;
      if (c == k[1]) v[heavy ? WH : WL] = 1'b1;
      if (c == k[2] || c == k[3] || c == k[4]) v[DR] = 1'b1;
      if (c == k[3]) v[RI] = 1'b1;
      if (c >= k[4] && c <= k[4] + 5) v[SP] = 1'b1;
      if (c == k[5]) v[DN] = 1'b1;
      push(v);
    end
  endtask

  task automatic check(input string tag);
    logic [8:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s observed=%b expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, e);
      end
    end
  endtask

  task automatic cyc(input string tag, input int c);
    @(negedge clk);
    check($sformatf("%s c%0d", tag, c));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; select = 1'b0; stop = 1'b0; idle = 1'b0; resp = 1'b1;
    #1;
    push('0); check("reset_async");
    @(negedge clk); rst = 1'b1;
    push('0); cyc("arm_idle", 0);

    // Normal program, start held until just before completion.
    start = 1'b1; select = 1'b0;
    push_prog(1'b0, 0, 40);
    for (int c = 0; c <= 40; c++) begin
      cyc("normal", c);
      if (c == 38) start = 1'b0;
    end

    // Heavy program; select changes mid-run must not matter.
    start = 1'b1; select = 1'b1;
    push_prog(1'b1, 0, 48);
    for (int c = 0; c <= 48; c++) begin
      cyc("heavy", c);
      if (c == 5) select = 1'b0;
      if (c == 46) start = 1'b0;
    end

    // Stop sampled in R_WASH at cycle 15.
    start = 1'b1; select = 1'b0;
    push_prog(1'b0, 0, 15);
    for (int c = 16; c <= 20; c++) push('0);
    for (int c = 0; c <= 20; c++) begin
      cyc("stop", c);
      if (c == 15) stop = 1'b1;
    end
    stop = 1'b0;

    // Restart after stop, then abort via idle during R_SOAK.
    push_prog(1'b0, 0, 2);
    for (int c = 3; c <= 5; c++) push('0);
    for (int c = 0; c <= 5; c++) begin
      cyc("restart_idle", c);
      if (c == 2) begin idle = 1'b1; start = 1'b0; end
    end
    idle = 1'b0;

    // Silent controller: soak kick held ACK_T cycles, then fault.
    resp = 1'b0; start = 1'b1;
    for (int c = 0; c <= 3; c++) push(9'b1 << SL);
    for (int c = 4; c <= 8; c++) push(9'b1 << FT);
    for (int c = 0; c <= 8; c++) begin
      cyc("noack", c);
      if (c == 0) start = 1'b0;
    end

    // Next accepted start clears fault.
    resp = 1'b1; start = 1'b1;
    push(9'b1 << SL); push('0); push('0);
    for (int c = 0; c <= 2; c++) begin
      cyc("fault_clear", c);
      if (c == 0) start = 1'b0;
      if (c == 1) stop = 1'b1;
    end
    stop = 1'b0;

    // Reset asserted between edges while in R_RINSE.
    start = 1'b1;
    push_prog(1'b0, 0, 27);
    for (int c = 0; c <= 27; c++) begin
      cyc("pre_reset", c);
      if (c == 0) start = 1'b0;
    end
    #2 rst = 1'b0;
    #1 push('0); check("reset_mid_rinse");
    push('0); cyc("reset_held", 0);
    rst = 1'b1;
    for (int c = 0; c <= 3; c++) push('0);
    for (int c = 0; c <= 3; c++) cyc("post_reset_quiet", c);
    start = 1'b1;
    push_prog(1'b0, 0, 1);
    for (int c = 0; c <= 1; c++) begin
      cyc("post_reset_start", c);
      if (c == 0) start = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wm_phase_timer.md
WM_PHASE_TIMER -- requirements
Module: wm_phase_timer

Interface
REQ-001 Parameters (name, default, meaning):
  SOAK_T, 8, normal soak duration in cycles
  WASH_T, 10, normal wash duration in cycles
  HI_EXTRA, 4, cycles added to soak and to wash when the heavy cycle is latched
  DRAIN_T, 4, drain duration in cycles
  RINSE_T, 6, rinse duration in cycles
  SPIN_T, 5, spin duration in cycles
  ACK_T, 4, maximum cycles a kick code is held without acknowledge
REQ-002 Ports (name direction width meaning):
  clk  input  1  clock; all state changes on the rising edge
  rst  input  1  asynchronous, active-low reset
  start  input  1  run request, level, sampled only in ARM
  select  input  1  cycle select: 0 normal, 1 heavy
  stop  input  1  abort, level
  idle  input  1  controller idle phase flag
  soak_low  input  1  controller normal-soak flag
  soak_high  input  1  controller heavy-soak flag
  wash_low  input  1  controller normal-wash flag
  wash_high  input  1  controller heavy-wash flag
  drain  input  1  controller drain flag
  rinse  input  1  controller rinse flag
  spin  input  1  controller spin flag
  timer_soak_low  output  1  normal-soak kick
  timer_soak_high  output  1  heavy-soak kick
  timer_wash_low  output  1  normal-wash kick
  timer_wash_high  output  1  heavy-wash kick
  timer_drain  output  1  drain kick / qualifier
  timer_rinse  output  1  rinse kick
  timer_spin  output  1  spin kick / spin hold
  done  output  1  one-cycle pulse on program completion
  fault  output  1  sticky acknowledge-timeout flag

Function
REQ-003 All outputs SHALL be registered; phase inputs SHALL be used unsynchronised (same clock domain).
REQ-004 States SHALL be ARM, and a kick/run pair per phase: K_SOAK/R_SOAK, K_WASH/R_WASH, K_DRAIN/R_DRAIN, K_RINSE/R_RINSE, K_SPIN/R_SPIN, plus K_END.
REQ-005 Timer codes (unlisted outputs 0): K_SOAK soak_low (sel_q=0) or soak_high (sel_q=1); K_WASH wash_low or wash_high; K_DRAIN drain; K_RINSE drain+rinse; K_SPIN spin+drain; R_SPIN spin; K_END, ARM and other R_x all zero.
REQ-006 Acknowledges: K_SOAK soak_low/soak_high=1 per sel_q; K_WASH wash_low/wash_high=1; K_DRAIN drain=1 and rinse=0; K_RINSE rinse=1; K_SPIN spin=1; K_END spin=0.
REQ-007 ARM: start=1 and stop=0 SHALL latch sel_q=select, clear fault, and enter K_SOAK; the code becomes visible in the first K_SOAK cycle.
REQ-008 K_x with acknowledge SHALL enter R_x and load a 16-bit counter with duration-1; a duration of 0 is treated as 1.
REQ-009 R_x SHALL last exactly its duration in cycles, decrementing the counter; at count 0 it SHALL enter the next kick state.
REQ-010 Soak duration SHALL be SOAK_T+HI_EXTRA and wash duration WASH_T+HI_EXTRA when sel_q=1; sel_q SHALL be frozen for the whole program.
REQ-011 K_x without acknowledge for ACK_T consecutive cycles (ACK_T=0 treated as 1) SHALL set fault=1, zero all timer outputs, and enter ARM; acknowledge wins over timeout in the same cycle.
REQ-012 K_END acknowledge SHALL enter ARM with done=1 for exactly that one cycle.
REQ-013 stop=1 in any non-ARM state SHALL enter ARM at the next edge with timer outputs 0, no done, and fault unchanged; stop has priority over acknowledge, expiry and timeout.
REQ-014 idle=1 in any non-ARM state SHALL abort exactly as stop does.
REQ-015 start falling mid-program SHALL NOT abort the program; the resulting missing acknowledge is handled by REQ-011.

Reset
REQ-016 rst=0 SHALL force, without a clock, state ARM, all timer outputs 0, done 0, fault 0, sel_q 0, and both counters 0; the first transition occurs on the first rising edge after rst=1.

Verification
REQ-017 Normal program: select=0, start held, controller model acks combinationally -> single-cycle kicks at cycles 0 (soak_low), 9 (wash_low), 20 (drain), 25 (drain+rinse), 32 (spin+drain); timer_spin high cycles 32-37; done=1 at cycle 39.
REQ-018 Heavy program: select=1 -> soak_high at cycle 0 and wash_high at cycle 13; done=1 at cycle 47; select toggled mid-run has no effect.
REQ-019 Stop: stop=1 sampled at cycle 15 (R_WASH) -> all timer outputs 0 from cycle 16, state ARM, done never set, fault 0; a new start is accepted.
REQ-020 No acknowledge: silent model -> timer_soak_low high for exactly 4 cycles, then fault=1 and outputs 0; the next accepted start clears fault.
REQ-021 Reset in R_RINSE: rst=0 between edges -> outputs 0 immediately; after release, no kick appears until start=1.
